// File: rtl/capture_frame_packer.sv
// Packs realtime timestamp/sample beats into header-led AXI-stream frames.
// One beat is held back so the frame's final beat can be tagged last before it is written.
module capture_frame_packer #(
   parameter int DATA_WIDTH   = 256,
   parameter int TS_WIDTH     = 64,
   parameter int FIFO_DEPTH   = 64,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic                  adc_clk,
   input  logic                  adc_reset_n,
   input  logic                  adc_reset_state,
   input  logic                  adc_data_valid,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  adc_ts_valid,
   input  logic [TS_WIDTH-1:0]   adc_ts,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  overflow,
   output logic [15:0]           frames_dropped
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_vld;
   logic [15:0]           seq;
   logic [IW-1:0]         idle_cnt;

   logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         free;

   logic                  wr_en, wr_last, pop, idle_timeout;
   logic [DATA_WIDTH-1:0] hdr_beat;

   assign free         = CW'(FIFO_DEPTH) - count;
   assign out_valid    = (count != '0);
   assign pop          = out_valid & out_ready;
   assign idle_timeout = (idle_cnt == IW'(IDLE_TIMEOUT - 1));

   // Empty FIFO presents all-zero data so reset forces out_data low immediately.
   assign {out_last, out_data} = out_valid ? mem[rd_ptr] : '0;

   always_comb begin
      hdr_beat = '0;
      hdr_beat[TS_WIDTH-1:0]   = adc_ts;
      hdr_beat[TS_WIDTH +: 16] = seq;
   end

   // The held beat is written when its successor (or the end of the frame) is known.
   always_comb begin
      wr_en   = 1'b0;
      wr_last = 1'b0;
      if (state == S_FRAME && hold_vld) begin
         if (adc_ts_valid) begin
            wr_en   = 1'b1;
            wr_last = 1'b1;
         end else if (adc_data_valid) begin
            wr_en   = 1'b1;
            wr_last = (free < CW'(2));
         end else if (idle_timeout) begin
            wr_en   = 1'b1;
            wr_last = 1'b1;
         end
      end
   end

   always_ff @(posedge adc_clk) begin
      if (wr_en) mem[wr_ptr] <= {wr_last, hold_data};
   end

   always_ff @(posedge adc_clk or negedge adc_reset_n) begin
      if (!adc_reset_n) begin
         state          <= S_IDLE;
         hold_data      <= '0;
         hold_vld       <= 1'b0;
         seq            <= '0;
         idle_cnt       <= '0;
         overflow       <= 1'b0;
         frames_dropped <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else if (adc_reset_state) begin
         state          <= S_IDLE;
         hold_data      <= '0;
         hold_vld       <= 1'b0;
         seq            <= '0;
         idle_cnt       <= '0;
         overflow       <= 1'b0;
         frames_dropped <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(pop);

         if (adc_ts_valid) begin
            // Three free slots: flush of the previous frame, header, and the reserved last slot.
            if (free >= CW'(3)) begin
               hold_data <= hdr_beat;
               hold_vld  <= 1'b1;
               seq       <= seq + 16'd1;
               idle_cnt  <= '0;
               state     <= S_FRAME;
            end else begin
               hold_vld <= 1'b0;
               if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
               state    <= S_DROP;
            end
         end else if (state == S_FRAME) begin
            if (adc_data_valid) begin
               if (free >= CW'(2)) begin
                  hold_data <= adc_data;
                  idle_cnt  <= '0;
               end else begin
                  hold_vld <= 1'b0;
                  overflow <= 1'b1;
                  state    <= S_DROP;
               end
            end else if (idle_timeout) begin
               hold_vld <= 1'b0;
               idle_cnt <= '0;
               state    <= S_IDLE;
            end else begin
               idle_cnt <= idle_cnt + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_capture_frame_packer.sv
// Bench for capture_frame_packer: queue-based reference model checked every cycle,
// directed frame scenarios with literal expectations, then randomized traffic.
module tb_capture_frame_packer;

   localparam int DW = 256;
   localparam int TW = 64;
   localparam int FD = 16;
   localparam int IT = 4;
   localparam int M_IDLE = 0, M_FRAME = 1, M_DROP = 2;

   logic          adc_clk, adc_reset_n, adc_reset_state;
   logic          adc_data_valid, adc_ts_valid;
   logic [DW-1:0] adc_data, out_data;
   logic [TW-1:0] adc_ts;
   logic          out_valid, out_last, out_ready, overflow;
   logic [15:0]   frames_dropped;

   capture_frame_packer #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .FIFO_DEPTH(FD), .IDLE_TIMEOUT(IT)) dut (
      .adc_clk(adc_clk), .adc_reset_n(adc_reset_n), .adc_reset_state(adc_reset_state),
      .adc_data_valid(adc_data_valid), .adc_data(adc_data),
      .adc_ts_valid(adc_ts_valid), .adc_ts(adc_ts),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .overflow(overflow), .frames_dropped(frames_dropped));

   initial adc_clk = 1'b0;
   always #5 adc_clk = ~adc_clk;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;
   int in_cyc  = 0;

   typedef struct {logic [DW:0] beat; int stamp;} xfer_t;
   xfer_t got[$];

   always @(posedge adc_clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] dval(input int i);
      logic [31:0] w;
      w = 32'hDA7A_0000 + 32'(i);
      return {8{w}};
   endfunction

   function automatic logic [DW:0] mk(input bit l, input logic [DW-1:0] d);
      return {l, d};
   endfunction

   function automatic logic [DW-1:0] hdr(input int s, input logic [TW-1:0] t);
      logic [DW-1:0] h;
      h = '0;
      h[TW-1:0]   = t;
      h[TW +: 16] = 16'(s);
      return h;
   endfunction

   // Reference model: output FIFO as a queue, one pending beat, frame mode.
   logic [DW:0]   m_q[$];
   logic [DW-1:0] m_hold;
   int            m_mode, m_idle, m_seq, m_drop, m_free;
   bit            m_ovf, m_pop, m_push;
   logic [DW:0]   m_pv;

   always @(posedge adc_clk or negedge adc_reset_n) begin
      if (!adc_reset_n || adc_reset_state) begin
         m_q.delete();
         m_hold = '0; m_mode = M_IDLE; m_idle = 0; m_seq = 0; m_drop = 0; m_ovf = 0;
      end else begin
         m_free = FD - m_q.size();
         m_pop  = (m_q.size() != 0) && out_ready;
         m_push = 0;
         m_pv   = '0;
         if (adc_ts_valid) begin
            if (m_mode == M_FRAME) begin m_push = 1; m_pv = {1'b1, m_hold}; end
            if (m_free >= 3) begin
               m_hold = hdr(m_seq, adc_ts);
               m_seq  = (m_seq + 1) % 65536;
               m_mode = M_FRAME;
               m_idle = 0;
            end else begin
               if (m_drop < 65535) m_drop++;
               m_mode = M_DROP;
            end
         end else if (m_mode == M_FRAME) begin
            if (adc_data_valid) begin
               m_push = 1;
               if (m_free >= 2) begin
                  m_pv = {1'b0, m_hold}; m_hold = adc_data; m_idle = 0;
               end else begin
                  m_pv = {1'b1, m_hold}; m_ovf = 1; m_mode = M_DROP;
               end
            end else begin
               m_idle++;
               if (m_idle == IT) begin
                  m_push = 1; m_pv = {1'b1, m_hold}; m_mode = M_IDLE; m_idle = 0;
               end
            end
         end
         if (m_pop) void'(m_q.pop_front());
         if (m_push) m_q.push_back(m_pv);
      end
   end

   // Per-cycle comparison against the model, plus a log of accepted beats.
   always @(negedge adc_clk) begin
      xfer_t x;
      chk("out_valid", 257'(out_valid), 257'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_beat", {out_last, out_data}, m_q[0]);
      else                 chk("out_idle_zero", {out_last, out_data}, '0);
      chk("overflow", 257'(overflow), 257'(m_ovf));
      chk("frames_dropped", 257'(frames_dropped), 257'(m_drop));
      if (out_valid && out_ready) begin
         x.beat  = {out_last, out_data};
         x.stamp = cyc_cnt;
         got.push_back(x);
      end
   end

   task automatic step(input bit tv, input logic [TW-1:0] t, input bit dv, input logic [DW-1:0] d);
      adc_ts_valid = tv; adc_ts = t; adc_data_valid = dv; adc_data = d;
      in_cyc = cyc_cnt;
      @(posedge adc_clk); #2;
      adc_ts_valid = 0; adc_data_valid = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, '0, 0, '0);
   endtask

   task automatic sclear();
      adc_reset_state = 1;
      @(posedge adc_clk); #2;
      adc_reset_state = 0;
      got.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      adc_reset_n = 0; adc_reset_state = 0; adc_ts_valid = 0; adc_ts = '0;
      adc_data_valid = 0; adc_data = '0; out_ready = 1;
      repeat (2) @(posedge adc_clk);
      #2 adc_reset_n = 1;
      chk("rst_valid", 257'(out_valid), 257'd0);
      chk("rst_ovf", 257'(overflow), 257'd0);
      chk("rst_drop", 257'(frames_dropped), 257'd0);

      // Basic frame: header, three data beats, timeout ends it.
      sclear();
      step(1, 64'h1234, 0, '0);
      step(0, '0, 1, dval(0));
      step(0, '0, 1, dval(1));
      step(0, '0, 1, dval(2));
      t = in_cyc;
      idle(8);
      chk("t27_count", 257'(got.size()), 257'd4);
      if (got.size() == 4) begin
         chk("t27_hdr", got[0].beat, 257'h1234);
         chk("t27_d0", got[1].beat, mk(0, dval(0)));
         chk("t27_d1", got[2].beat, mk(0, dval(1)));
         chk("t27_d2", got[3].beat, mk(1, dval(2)));
         chk("t27_lat", 257'(got[3].stamp), 257'(t + 5));
      end

      // Header-only frame.
      sclear();
      step(1, 64'h55, 0, '0);
      t = in_cyc;
      idle(8);
      chk("t28_count", 257'(got.size()), 257'd1);
      if (got.size() == 1) begin
         chk("t28_hdr", got[0].beat, {1'b1, 256'h55});
         chk("t28_lat", 257'(got[0].stamp), 257'(t + 5));
      end

      // Backpressure overflow: FIFO fills with header + D0..D14, rest dropped.
      sclear();
      out_ready = 0;
      step(1, 64'h29, 0, '0);
      for (int i = 0; i < 20; i++) step(0, '0, 1, dval(i));
      idle(3);
      chk("t29_ovf", 257'(overflow), 257'd1);
      chk("t29_valid", 257'(out_valid), 257'd1);
      out_ready = 1;
      idle(20);
      chk("t29_count", 257'(got.size()), 257'd16);
      if (got.size() == 16) begin
         chk("t29_hdr", got[0].beat, mk(0, 256'h29));
         for (int i = 0; i < 15; i++) chk("t29_data", got[i+1].beat, mk(i == 14, dval(i)));
      end

      // Back-to-back frames: the second timestamp closes the first frame.
      sclear();
      step(1, 64'hAAAA, 0, '0);
      step(0, '0, 1, dval(0));
      step(0, '0, 1, dval(1));
      step(1, 64'hBBBB, 0, '0);
      step(0, '0, 1, dval(2));
      idle(8);
      chk("t30_count", 257'(got.size()), 257'd5);
      if (got.size() == 5) begin
         chk("t30_hdra", got[0].beat, 257'hAAAA);
         chk("t30_d0", got[1].beat, mk(0, dval(0)));
         chk("t30_d1", got[2].beat, mk(1, dval(1)));
         chk("t30_hdrb", got[3].beat, 257'h1_0000_0000_0000_BBBB);
         chk("t30_d2", got[4].beat, mk(1, dval(2)));
      end

      // Data without a timestamp produces nothing.
      sclear();
      for (int i = 0; i < 5; i++) step(0, '0, 1, dval(i));
      idle(4);
      chk("t31_count", 257'(got.size()), 257'd0);
      chk("t31_valid", 257'(out_valid), 257'd0);

      // Async reset while output is pending; first frame afterwards restarts at seq 0.
      sclear();
      out_ready = 0;
      step(1, 64'h32, 0, '0);
      for (int i = 0; i < 20; i++) step(0, '0, 1, dval(i));
      step(1, 64'h33, 0, '0);
      chk("t32_drop", 257'(frames_dropped), 257'd1);
      chk("t32_valid_pre", 257'(out_valid), 257'd1);
      adc_reset_n = 0;
      #1;
      chk("t32_rst_valid", 257'(out_valid), 257'd0);
      chk("t32_rst_beat", {out_last, out_data}, '0);
      chk("t32_rst_ovf", 257'(overflow), 257'd0);
      chk("t32_rst_drop", 257'(frames_dropped), 257'd0);
      @(posedge adc_clk); #2;
      adc_reset_n = 1;
      out_ready = 1;
      got.delete();
      step(1, 64'h77, 0, '0);
      step(0, '0, 1, dval(7));
      idle(8);
      chk("t32_count", 257'(got.size()), 257'd2);
      if (got.size() == 2) begin
         chk("t32_hdr", got[0].beat, mk(0, 256'h77));
         chk("t32_d", got[1].beat, mk(1, dval(7)));
      end
      chk("t32_ovf", 257'(overflow), 257'd0);

      // Randomized traffic, alternating light and heavy backpressure.
      got.delete();
      for (int n = 0; n < 4000; n++) begin
         logic [DW-1:0] d;
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         out_ready       = ((n / 300) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 10 != 0);
         adc_reset_state = ($urandom % 400 == 0);
         step($urandom % 16 == 0, {$urandom, $urandom}, $urandom % 10 < 6, d);
         adc_reset_state = 0;
      end
      out_ready = 1;
      idle(30);
      chk("final_empty", 257'(out_valid), 257'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/capture_frame_packer.md
CAPTURE_FRAME_PACKER -- requirements
Module: capture_frame_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, giving the sample beat width (16 samples x 16 bits).
REQ-002 SHALL have parameter TS_WIDTH, default 64, giving the timestamp width ({time, sample_index}).
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, a power of two >= 4, giving the output FIFO entries.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 8, >= 1, giving the data-gap cycles that end a frame.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports: adc_clk in 1 (sole clock); adc_reset_n in 1 (async active-low reset).
REQ-006 SHALL have port adc_reset_state in 1, a synchronous clear.
REQ-007 SHALL have ports adc_data_valid in 1 and adc_data in DATA_WIDTH: a realtime discriminated sample beat with no backpressure.
REQ-008 SHALL have ports adc_ts_valid in 1 and adc_ts in TS_WIDTH: a realtime capture-start timestamp pulse.
REQ-009 SHALL have ports out_data out DATA_WIDTH, out_valid out 1, out_last out 1 and out_ready in 1, forming an AXI-stream master.
REQ-010 SHALL have ports overflow out 1 (sticky) and frames_dropped out 16 (saturating count).

Function
REQ-011 A transfer on the output occurs when out_valid & out_ready; out_data and out_last SHALL be held stable while out_valid & !out_ready.
REQ-012 FSM states: IDLE, FRAME, DROP.
- Reset state: IDLE.
- A hold register stores one pending beat {data, valid}.
REQ-013 Header beat format: bits [TS_WIDTH-1:0] = adc_ts; [TS_WIDTH+15:TS_WIDTH] = 16-bit frame sequence number (wraps 0xFFFF->0); other bits 0.
REQ-014 free = FIFO_DEPTH - occupancy, registered at cycle start; an output pop in the same cycle is not credited.
REQ-015 adc_ts_valid in any state:
- If FRAME, flush hold with last=1.
- If free >= 3: load header into hold, increment sequence, go FRAME.
- Else: increment frames_dropped, go DROP.
REQ-016 adc_data_valid in FRAME without adc_ts_valid:
- If free >= 2: push hold with last=0, load data into hold.
- Else: push hold with last=1, drop the data, set overflow, clear hold, go DROP.
REQ-017 adc_data_valid in IDLE or DROP, or coinciding with adc_ts_valid, SHALL drop the beat with no other effect.
REQ-018 Idle counter:
- Resets on each data beat or header load in FRAME.
- Reaching IDLE_TIMEOUT consecutive cycles with no data SHALL flush hold with last=1 and go IDLE.
REQ-019 A header-only frame (no data before timeout or next ts) SHALL emit one beat with out_last=1.
REQ-020 At most one FIFO write per cycle. Every frame written SHALL end with last=1, guaranteed by the one-slot reservation in REQ-016.
REQ-021 Latency:
- A beat written at cycle t into an empty FIFO SHALL present out_valid=1 at t+1.
- A data beat is written the cycle after the next beat or timeout.
REQ-022 FIFO ordering SHALL be strict FIFO; pushes and pops may occur in the same cycle.
REQ-023 frames_dropped SHALL saturate at 0xFFFF; overflow SHALL clear only on reset or adc_reset_state.

Reset
REQ-024 adc_reset_n low SHALL immediately force:
- out_valid=0, out_last=0, out_data=0;
- FIFO empty, hold cleared, state IDLE;
- sequence 0, idle counter 0, overflow 0, frames_dropped 0.
REQ-025 adc_reset_state=1 at a clock edge SHALL apply the same clear synchronously and ignore same-cycle inputs.
REQ-026 Reset mid-frame SHALL discard partial frames; the first frame after reset SHALL carry sequence 0.

Verification (FIFO_DEPTH=16, IDLE_TIMEOUT=4, out_ready=1 unless noted)
REQ-027 ts=0x1234, then D0,D1,D2 on consecutive cycles, then idle -> output hdr{seq0,0x1234}, D0, D1, D2; out_last only on D2; D2 appears 5 cycles after its input.
REQ-028 ts alone, no data -> single hdr{seq0} with out_last=1, 5 cycles after ts.
REQ-029 out_ready=0, ts, then D0..D19 consecutive -> FIFO holds 16 beats: hdr, D0..D14, last on D14; D15..D19 dropped; overflow=1; then out_ready=1 drains exactly 16 beats.
REQ-030 ts A, D0, D1, ts B, D2, idle -> hdrA(seq0), D0, D1(last); hdrB(seq1), D2(last).
REQ-031 data beats with no preceding ts -> no output, out_valid stays 0.
REQ-032 adc_reset_n low while out_valid=1 -> out_valid=0 same cycle; after release, the next frame carries seq0 and overflow=0.
